// File: rtl/response_checker_pkg.sv
// Shared types and widths for the response checker: FSM state encoding and latency field width.
package response_checker_pkg;
  localparam int STATE_W   = 2;
  localparam int LAT_W     = 4;
  localparam int DEF_WIDTH = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;
endpackage

// File: rtl/check_delay_line.sv
// Fixed-depth shift register of {valid, payload} with a runtime-selected tap (1..STAGES)
// and a synchronous clear of every valid bit. Payload registers carry no reset.
module check_delay_line
  import response_checker_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int STAGES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_vld,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LAT_W-1:0]  tap_sel,
  output logic              tap_vld,
  output logic [DATA_W-1:0] tap_data
);
  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] vld_nxt;
  logic [DATA_W-1:0] data_p [STAGES];

  generate
    if (STAGES == 1) begin : g_one
      assign vld_nxt = in_vld;
    end else begin : g_many
      assign vld_nxt = {vld_p[STAGES-2:0], in_vld};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       vld_p <= '0;
    else if (clr_vld) vld_p <= '0;
    else              vld_p <= vld_nxt;
  end

  always_ff @(posedge clk) begin
    data_p[0] <= in_data;
    for (int k = 1; k < STAGES; k++) data_p[k] <= data_p[k-1];
  end

  always_comb begin
    tap_vld  = 1'b0;
    tap_data = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (tap_sel == LAT_W'(k + 1)) begin
        tap_vld  = vld_p[k];
        tap_data = data_p[k];
      end
    end
  end
endmodule

// File: rtl/response_checker.sv
// Delays a+b by the programmed DUT latency and scores it against the DUT result.
// Optional first-mismatch capture of exp/got/a/b: define RESPONSE_CHECKER_CAPTURE_EN.
module response_checker
  import response_checker_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LAT_MAX   = 8,
  parameter int CTR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 freeze,
  input  logic [LAT_W-1:0]     i_latency,
  input  logic                 i_valid,
  input  logic [WIDTH-1:0]     i_drive_a,
  input  logic [WIDTH-1:0]     i_drive_b,
  input  logic [WIDTH-1:0]     i_dut_out,
  output logic                 o_mismatch,
  output logic [CTR_WIDTH-1:0] o_chk_ctr,
  output logic [CTR_WIDTH-1:0] o_err_ctr,
  output logic [STATE_W-1:0]   o_state,
  output logic [WIDTH-1:0]     o_cap_exp,
  output logic [WIDTH-1:0]     o_cap_got,
  output logic [WIDTH-1:0]     o_cap_a,
  output logic [WIDTH-1:0]     o_cap_b
);
`ifdef RESPONSE_CHECKER_CAPTURE_EN
  localparam int LINE_W = 3 * WIDTH;
`else
  localparam int LINE_W = WIDTH;
`endif

  state_e            state;
  logic [LAT_W-1:0]  lat_q;
  logic [LAT_W-1:0]  fill_cnt;
  logic [WIDTH-1:0]  exp_p0;
  logic [LINE_W-1:0] line_in;
  logic [LINE_W-1:0] tap_data;
  logic [WIDTH-1:0]  tap_exp;
  logic              tap_vld;
  logic              compare;
  logic              miss;

  function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] l);
    if (l == '0) return LAT_W'(1);
    if (l > LAT_W'(LAT_MAX)) return LAT_W'(LAT_MAX);
    return l;
  endfunction

  function automatic logic [CTR_WIDTH-1:0] sat_inc(input logic [CTR_WIDTH-1:0] c);
    return (&c) ? c : c + CTR_WIDTH'(1);
  endfunction

  // Stage p0: modular expected sum enters the delay line
  assign exp_p0 = i_drive_a + i_drive_b;
`ifdef RESPONSE_CHECKER_CAPTURE_EN
  assign line_in = {exp_p0, i_drive_a, i_drive_b};
`else
  assign line_in = exp_p0;
`endif

  check_delay_line #(.DATA_W(LINE_W), .STAGES(LAT_MAX)) u_line (
    .clk      (clk),
    .reset    (reset),
    .clr_vld  (!enable),
    .in_vld   (i_valid),
    .in_data  (line_in),
    .tap_sel  (lat_q),
    .tap_vld  (tap_vld),
    .tap_data (tap_data)
  );

  // Tap stage: compare only while checking; HOLD lets entries fall off unchecked
  assign tap_exp = tap_data[LINE_W-1 -: WIDTH];
  assign compare = (state == ST_CHECK) && tap_vld;
  assign miss    = compare && (i_dut_out != tap_exp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      lat_q    <= LAT_W'(1);
      fill_cnt <= '0;
    end else if (!enable) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_FILL;
          lat_q    <= clamp_lat(i_latency);
          fill_cnt <= clamp_lat(i_latency) - LAT_W'(1);
        end
        ST_FILL: begin
          if (fill_cnt == '0) state <= ST_CHECK;
          else                fill_cnt <= fill_cnt - LAT_W'(1);
        end
        ST_CHECK: if (freeze)  state <= ST_HOLD;
        ST_HOLD:  if (!freeze) state <= ST_CHECK;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign o_state = state;

  // Result stage p1: registered pulse and saturating scoreboard counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_mismatch <= 1'b0;
      o_chk_ctr  <= '0;
      o_err_ctr  <= '0;
    end else begin
      o_mismatch <= miss;
      if (compare) o_chk_ctr <= sat_inc(o_chk_ctr);
      if (miss)    o_err_ctr <= sat_inc(o_err_ctr);
    end
  end

`ifdef RESPONSE_CHECKER_CAPTURE_EN
  logic cap_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_done  <= 1'b0;
      o_cap_exp <= '0;
      o_cap_got <= '0;
      o_cap_a   <= '0;
      o_cap_b   <= '0;
    end else if (miss && !cap_done) begin
      cap_done  <= 1'b1;
      o_cap_exp <= tap_exp;
      o_cap_got <= i_dut_out;
      o_cap_a   <= tap_data[2*WIDTH-1:WIDTH];
      o_cap_b   <= tap_data[WIDTH-1:0];
    end
  end
`else
  assign o_cap_exp = '0;
  assign o_cap_got = '0;
  assign o_cap_a   = '0;
  assign o_cap_b   = '0;
`endif
endmodule
